// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: tag-invalidate sweep, dirty-victim write-back and line refill ahead of the tag RAM; define REFILL_BYPASS_EN for early-restart bypass
module cache_refill_ctrl #(
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 5,
  parameter int TAG_W    = 20
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        miss_valid,
  output logic                        miss_ready,
  input  logic [31:0]                 miss_addr,
  input  logic                        miss_way,
  input  logic                        miss_victim_dirty,
  input  logic [TAG_W-1:0]            miss_victim_tag,
  input  logic                        miss_store,
  output logic                        refill_done,
  output logic [INDEX_W+OFFSET_W-3:0] dram_raddr,
  input  logic [31:0]                 dram_rdata,
  output logic                        dram_we,
  output logic [INDEX_W+OFFSET_W-3:0] dram_waddr,
  output logic                        dram_wway,
  output logic [31:0]                 dram_wdata,
  output logic                        cache_reset,
  output logic [INDEX_W-1:0]          tag_waddr,
  output logic [1:0]                  tag_we,
  output logic [2*TAG_W+4:0]          tag_din,
  output logic                        tag_refill,
  output logic                        tag_load_over,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_wr,
  output logic [31:0]                 mem_req_addr,
  output logic                        mem_wvalid,
  input  logic                        mem_wready,
  output logic [31:0]                 mem_wdata,
  output logic                        mem_wlast,
  input  logic                        mem_bvalid,
  input  logic                        mem_rvalid,
  input  logic [31:0]                 mem_rdata,
  input  logic                        mem_rlast,
  output logic                        err
`ifdef REFILL_BYPASS_EN
  ,
  output logic                        bypass_valid,
  output logic [31:0]                 bypass_data
`endif
);
  localparam int BW = OFFSET_W - 2;
  localparam logic [BW-1:0] LAST = '1;
  typedef enum logic [3:0] {INIT, IDLE, WB_REQ, WB_DATA, WB_RESP, RD_REQ, RD_DATA, TAG_WR, DONE} state_t;
  state_t st, nx;
  logic [INDEX_W-1:0] sweep, idx_q;
  logic [BW-1:0] beat;
  logic [TAG_W-1:0] tag_q, vtag_q;
  logic way_q, store_q, hold_v, wb_fire, rd_fire, bad;
  logic [31:0] hold_q;
  logic [TAG_W:0] new_f;
  logic unused_ok;
`ifdef REFILL_BYPASS_EN
  logic [BW-1:0] off_q;
`endif
  assign unused_ok = &{1'b0, miss_addr[OFFSET_W-1:0]};
  assign wb_fire = mem_wvalid && mem_wready;
  assign rd_fire = st == RD_DATA && mem_rvalid;
  assign bad = (mem_rvalid && st != RD_DATA) || (mem_bvalid && st != WB_RESP) ||
               (rd_fire && (mem_rlast != (beat == LAST)));
  // state, counters, miss capture, write-data hold and sticky error
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      st      <= INIT;
      sweep   <= '0;
      beat    <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      way_q   <= 1'b0;
      store_q <= 1'b0;
      hold_q  <= '0;
      hold_v  <= 1'b0;
      err     <= 1'b0;
`ifdef REFILL_BYPASS_EN
      off_q   <= '0;
`endif
    end else begin
      st <= nx;
      if (st == INIT) sweep <= sweep + 1'b1;
      if (wb_fire || rd_fire) beat <= beat + 1'b1;
      if (miss_valid && miss_ready) begin
        idx_q   <= miss_addr[OFFSET_W +: INDEX_W];
        tag_q   <= miss_addr[31 -: TAG_W];
        vtag_q  <= miss_victim_tag;
        way_q   <= miss_way;
        store_q <= miss_store;
`ifdef REFILL_BYPASS_EN
        off_q   <= miss_addr[OFFSET_W-1:2];
`endif
      end
      hold_q <= mem_wdata;
      hold_v <= mem_wvalid && !mem_wready;
      if (bad) err <= 1'b1;
    end
  // next-state: beat counter wraps to 0 on the last beat, so each burst starts clean
  always_comb begin
    nx = st;
    case (st)
      INIT:    nx = &sweep ? IDLE : INIT;
      IDLE:    nx = miss_valid ? (miss_victim_dirty ? WB_REQ : RD_REQ) : IDLE;
      WB_REQ:  nx = mem_req_ready ? WB_DATA : WB_REQ;
      WB_DATA: nx = (mem_wready && beat == LAST) ? WB_RESP : WB_DATA;
      WB_RESP: nx = mem_bvalid ? RD_REQ : WB_RESP;
      RD_REQ:  nx = mem_req_ready ? RD_DATA : RD_REQ;
      RD_DATA: nx = (mem_rvalid && beat == LAST) ? TAG_WR : RD_DATA;
      TAG_WR:  nx = DONE;
      default: nx = IDLE;
    endcase
  end
  assign miss_ready    = st == IDLE;
  assign cache_reset   = st != INIT;
  assign mem_req_valid = st == WB_REQ || st == RD_REQ;
  assign mem_req_wr    = st == WB_REQ;
  assign mem_req_addr  = st == WB_REQ ? {vtag_q, idx_q, {OFFSET_W{1'b0}}} :
                         st == RD_REQ ? {tag_q, idx_q, {OFFSET_W{1'b0}}} : '0;
  assign mem_wvalid    = st == WB_DATA;
  assign mem_wlast     = mem_wvalid && beat == LAST;
  assign mem_wdata     = !mem_wvalid ? '0 : hold_v ? hold_q : dram_rdata;
  // prefetch the word the bus will want next cycle, given the RAM's 1-cycle latency
  assign dram_raddr    = {idx_q, beat + BW'(wb_fire)};
  assign dram_we       = rd_fire;
  assign dram_waddr    = {idx_q, beat};
  assign dram_wway     = way_q;
  assign dram_wdata    = rd_fire ? mem_rdata : '0;
  assign tag_refill    = st == TAG_WR;
  assign tag_waddr     = st == INIT ? sweep : idx_q;
  assign tag_we        = tag_refill ? (way_q ? 2'b10 : 2'b01) : 2'b00;
  assign new_f         = {1'b1, tag_q};
  assign tag_din       = !tag_refill ? '0 :
                         way_q ? {1'b0, store_q, new_f, 1'b0, {(TAG_W+1){1'b0}}} :
                                 {1'b1, 1'b0, {(TAG_W+1){1'b0}}, store_q, new_f};
  assign tag_load_over = st == DONE;
  assign refill_done   = st == DONE;
`ifdef REFILL_BYPASS_EN
  assign bypass_valid  = rd_fire && beat == off_q;
  assign bypass_data   = bypass_valid ? mem_rdata : '0;
`endif
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized directed bench for cache_refill_ctrl with a spec-level memory and tag model
module tb_cache_refill_ctrl;
  localparam int INDEX_W = 7, OFFSET_W = 5, TAG_W = 20, AW = INDEX_W + OFFSET_W - 2;
  logic clk = 1'b0, resetn;
  logic miss_valid, miss_ready, miss_way, miss_victim_dirty, miss_store, refill_done;
  logic [31:0] miss_addr;
  logic [TAG_W-1:0] miss_victim_tag;
  logic [AW-1:0] dram_raddr, dram_waddr;
  logic [31:0] dram_rdata, dram_wdata, mem_req_addr, mem_wdata, mem_rdata;
  logic dram_we, dram_wway, cache_reset, tag_refill, tag_load_over;
  logic [INDEX_W-1:0] tag_waddr;
  logic [1:0] tag_we;
  logic [2*TAG_W+4:0] tag_din;
  logic mem_req_valid, mem_req_ready, mem_req_wr, mem_wvalid, mem_wready, mem_wlast;
  logic mem_bvalid, mem_rvalid, mem_rlast, err;
`ifdef REFILL_BYPASS_EN
  logic bypass_valid;
  logic [31:0] bypass_data;
`endif
  logic [31:0] vic [0:(1<<AW)-1];
  int checks = 0, errors = 0;
  bit err_exp = 0;

  cache_refill_ctrl dut (
    .clk(clk), .resetn(resetn), .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_way(miss_way), .miss_victim_dirty(miss_victim_dirty), .miss_victim_tag(miss_victim_tag),
    .miss_store(miss_store), .refill_done(refill_done), .dram_raddr(dram_raddr), .dram_rdata(dram_rdata),
    .dram_we(dram_we), .dram_waddr(dram_waddr), .dram_wway(dram_wway), .dram_wdata(dram_wdata),
    .cache_reset(cache_reset), .tag_waddr(tag_waddr), .tag_we(tag_we), .tag_din(tag_din),
    .tag_refill(tag_refill), .tag_load_over(tag_load_over), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
    .mem_bvalid(mem_bvalid), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .err(err)
`ifdef REFILL_BYPASS_EN
    , .bypass_valid(bypass_valid), .bypass_data(bypass_data)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) dram_rdata <= vic[dram_raddr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sweep_check();
    int lows = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cache_reset) break;
      lows++;
    end
    chk("sweep_len", lows, 128);
    chk("ready_after_sweep", miss_ready, 1);
  endtask

  task automatic run_miss(input logic [31:0] a, input logic w, input logic d, input logic [TAG_W-1:0] vt,
                          input logic st, input bit zw, input int stall_beat, input int rlast_beat,
                          input int rst_beat);
    logic [INDEX_W-1:0] idx;
    logic [31:0] rd [8];
    logic [2*TAG_W+4:0] exp_din;
    int c, wb, rb, stall_left, tags;
    bit stalled, wdone, bsent, wreq_done, rreq_done;
    idx = a[OFFSET_W +: INDEX_W];
    foreach (rd[i]) rd[i] = $urandom;
    exp_din = w ? {1'b0, st, 1'b1, a[31 -: TAG_W], 1'b0, {(TAG_W+1){1'b0}}}
                : {1'b1, 1'b0, {(TAG_W+1){1'b0}}, st, 1'b1, a[31 -: TAG_W]};
    wb = 0; rb = 0; stall_left = 0; tags = 0;
    stalled = 0; wdone = 0; bsent = 0; wreq_done = 0; rreq_done = 0;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!miss_ready && c < 500);
    chk("ready_wait", miss_ready, 1);
    miss_valid = 1'b1; miss_addr = a; miss_way = w; miss_victim_dirty = d;
    miss_victim_tag = vt; miss_store = st;
    for (c = 2; c < 400; c++) begin
      @(posedge clk); #1;
      miss_valid = 1'b0;
      mem_req_ready = zw ? 1'b1 : 1'($urandom_range(0, 1));
      if (stall_left > 0) begin mem_wready = 1'b0; stall_left--; end
      else if (!stalled && mem_wvalid && wb == stall_beat) begin stalled = 1; stall_left = 2; mem_wready = 1'b0; end
      else mem_wready = zw ? 1'b1 : 1'($urandom_range(0, 1));
      mem_bvalid = wdone && !bsent;
      mem_rvalid = rreq_done && rb < 8 && (zw || $urandom_range(0, 1) == 1);
      mem_rdata = mem_rvalid ? rd[rb % 8] : $urandom;
      mem_rlast = mem_rvalid && rb == rlast_beat;
      @(negedge clk);
      if (mem_bvalid) bsent = 1;
      if (mem_req_valid) begin
        if (d && !wreq_done) begin
          chk("wb_req_wr", mem_req_wr, 1);
          chk("wb_req_addr", mem_req_addr, {vt, idx, 5'b0});
          if (mem_req_ready) wreq_done = 1;
        end else begin
          chk("rd_req_wr", mem_req_wr, 0);
          chk("rd_req_addr", mem_req_addr, {a[31:OFFSET_W], 5'b0});
          chk("rd_after_bvalid", bsent, d);
          if (mem_req_ready) rreq_done = 1;
        end
      end
      if (mem_wvalid) begin
        chk("wb_extra_beat", wb < 8, 1);
        chk("wb_wdata", mem_wdata, vic[{idx, 3'(wb)}]);
        chk("wb_wlast", mem_wlast, wb == 7);
        if (mem_wready) begin wb++; if (wb == 8) wdone = 1; end
      end
      if (mem_rvalid) begin
        chk("dram_we", dram_we, 1);
        chk("dram_waddr", dram_waddr, {idx, 3'(rb)});
        chk("dram_wway", dram_wway, w);
        chk("dram_wdata", dram_wdata, rd[rb]);
`ifdef REFILL_BYPASS_EN
        chk("bypass_valid", bypass_valid, rb == a[4:2]);
        if (rb == a[4:2]) chk("bypass_data", bypass_data, rd[rb]);
`endif
        if (mem_rlast != (rb == 7)) err_exp = 1;
        if (rb == rst_beat) begin
          #2 resetn = 1'b0;
          #1;
          chk("rst_req_valid", mem_req_valid, 0);
          chk("rst_wvalid", mem_wvalid, 0);
          chk("rst_dram_we", dram_we, 0);
          chk("rst_cache_reset", cache_reset, 0);
          chk("rst_err", err, 0);
          chk("rst_miss_ready", miss_ready, 0);
          mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_bvalid = 1'b0; err_exp = 0;
          return;
        end
        rb++;
      end else chk("dram_we_quiet", dram_we, 0);
      chk("load_over_with_done", tag_load_over, refill_done);
      if (tag_refill) begin
        tags++;
        chk("tag_we", tag_we, w ? 2'b10 : 2'b01);
        chk("tag_waddr", tag_waddr, idx);
        chk("tag_din", tag_din, exp_din);
      end
      if (refill_done) begin
        chk("done_not_ready", miss_ready, 0);
        chk("tag_write_once", tags, 1);
        chk("rd_beats", rb, 8);
        chk("wb_beats", wb, d ? 8 : 0);
        chk("err_state", err, err_exp);
        if (zw && !d) chk("clean_latency", c, 12);
        if (d && stall_beat >= 0) chk("stall_seen", stalled, 1);
        break;
      end
    end
    chk("done_in_time", c < 400, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_done", miss_ready, 1);
  endtask

  initial begin
    foreach (vic[i]) vic[i] = $urandom;
    miss_valid = 0; miss_addr = 0; miss_way = 0; miss_victim_dirty = 0; miss_victim_tag = 0; miss_store = 0;
    mem_req_ready = 0; mem_wready = 0; mem_bvalid = 0; mem_rvalid = 0; mem_rdata = 0; mem_rlast = 0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cache_reset", cache_reset, 0);
    chk("rst_miss_ready", miss_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_wvalid", mem_wvalid, 0);
    chk("rst_tag_we", tag_we, 0);
    chk("rst_tag_din", tag_din, 0);
    chk("rst_done", refill_done, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    sweep_check();
    run_miss(32'h1FC0_0A44, 1'b1, 1'b0, 20'h0, 1'b0, 1'b1, -1, 7, -1);
    run_miss({20'($urandom), 7'h10, 5'($urandom)}, 1'b0, 1'b1, 20'h00ABC, 1'b0, 1'b0, 3, 7, -1);
    run_miss({20'($urandom), 7'h10, 5'($urandom)}, 1'b1, 1'b1, 20'h00ABC, 1'b1, 1'b1, 5, 7, -1);
    for (int k = 0; k < 8; k++)
      run_miss($urandom, 1'($urandom), 1'($urandom), 20'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 7)), 7, -1);
    run_miss($urandom, 1'b0, 1'b0, 20'($urandom), 1'b1, 1'b1, -1, 7, -1);
    run_miss({20'($urandom), 7'($urandom), 5'h14}, 1'($urandom), 1'b0, 20'($urandom), 1'b0, 1'b1, -1, 7, -1);
    run_miss($urandom, 1'b1, 1'b0, 20'($urandom), 1'b0, 1'b1, -1, 5, -1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", err, 1);
    run_miss($urandom, 1'b1, 1'b1, 20'($urandom), 1'b0, 1'b0, 2, 7, 3);
    sweep_check();
    chk("err_clear_after_sweep", err, 0);
    @(posedge clk); #1;
    mem_bvalid = 1'b1;
    @(posedge clk); #1;
    mem_bvalid = 1'b0;
    @(negedge clk);
    chk("stray_bvalid_err", err, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
